mmc1_write_decoder: RTL and testbench

// - CPU-write side of the cartridge bus: decodes 6502 writes to $8000-$FFFF into MMC1 bank/control registers.
// - Serial 5-write load protocol.
// - Outputs the bank-mapped PRG SDRAM byte address, the CHR byte address and the CIRAM A10 mirroring select.
// - Sits beside the CPU read-path responder.
// - Runs on the 50MHz fabric clock; the asynchronous CPU strobe is synchronised internally.

---
 rtl/mmc1_write_decoder_if.sv | 25 ++
 rtl/mmc1_write_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_mmc1_write_decoder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmc1_write_decoder_if.sv
// CPU cartridge-bus view used by the MMC1 write decoder: M2 strobe, direction, ROM select, address, data.
// Bus contents are qualified only by cpu_m2 being high; there is no ready/back-pressure.
interface mmc1_write_decoder_if;
    logic        cpu_m2;
    logic        cpu_rw;
    logic        cpu_rom_sel_n;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_in;

    modport master (
        output cpu_m2,
        output cpu_rw,
        output cpu_rom_sel_n,
        output cpu_addr,
        output cpu_data_in
    );

    modport slave (
        input cpu_m2,
        input cpu_rw,
        input cpu_rom_sel_n,
        input cpu_addr,
        input cpu_data_in
    );
endinterface

// File: rtl/mmc1_write_decoder.sv
// MMC1 CPU-write decoder: serial 5-write register load plus PRG/CHR/CIRAM mapping on the fabric clock.
// Optional macro MMC1_CONSEC_IGNORE_EN drops writes that closely follow an accepted write (RMW double-write).
module mmc1_write_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CONSEC_CLKS = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    mmc1_write_decoder_if.slave        cpu,
    input  logic [12:0]                ppu_addr,
    output logic [17:0]                prg_addr,
    output logic [16:0]                chr_addr,
    output logic                       ciram_a10,
    output logic                       wram_en_n,
    output logic                       reg_wr,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_M2_HIGH = 2'd1,
        ST_EVAL    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] m2_sync_q, m2_sync_d;
    logic                   m2_prev_q, m2_prev_d;
    logic                   m2_s, m2_rise, m2_fall;

    logic       cap_rw_q, cap_rw_d;
    logic       cap_rom_sel_n_q, cap_rom_sel_n_d;
    logic [1:0] cap_sel_q, cap_sel_d;
    logic       cap_d7_q, cap_d7_d;
    logic       cap_d0_q, cap_d0_d;
    logic       unused_data;

    state_t     state_q, state_d;
    logic [4:0] shift_q, shift_d;
    logic [2:0] count_q, count_d;
    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prg_q, prg_d;
    logic       reg_wr_q, reg_wr_d;
    logic [4:0] commit_val;
    logic       wr_event, accept, take;

    logic [17:0] prg_addr_q, prg_addr_d;
    logic [16:0] chr_addr_q, chr_addr_d;
    logic        ciram_a10_q, ciram_a10_d;

    // Sync chain and edge history reset to 1 so an M2 already high at release produces no rise.
    assign m2_s    = m2_sync_q[SYNC_STAGES-1];
    assign m2_rise = m2_s & ~m2_prev_q;
    assign m2_fall = ~m2_s & m2_prev_q;

    always_comb begin
        m2_sync_d = {m2_sync_q[SYNC_STAGES-2:0], cpu.cpu_m2};
        m2_prev_d = m2_s;
    end

    // Only the bits the register protocol needs are kept from each capture.
    assign unused_data = ^cpu.cpu_data_in[6:1];

    always_comb begin
        cap_rw_d        = cap_rw_q;
        cap_rom_sel_n_d = cap_rom_sel_n_q;
        cap_sel_d       = cap_sel_q;
        cap_d7_d        = cap_d7_q;
        cap_d0_d        = cap_d0_q;
        if (m2_s) begin
            cap_rw_d        = cpu.cpu_rw;
            cap_rom_sel_n_d = cpu.cpu_rom_sel_n;
            cap_sel_d       = cpu.cpu_addr[14:13];
            cap_d7_d        = cpu.cpu_data_in[7];
            cap_d0_d        = cpu.cpu_data_in[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m2_sync_q       <= '1;
            m2_prev_q       <= 1'b1;
            cap_rw_q        <= 1'b1;
            cap_rom_sel_n_q <= 1'b1;
            cap_sel_q       <= 2'd0;
            cap_d7_q        <= 1'b0;
            cap_d0_q        <= 1'b0;
        end else begin
            m2_sync_q       <= m2_sync_d;
            m2_prev_q       <= m2_prev_d;
            cap_rw_q        <= cap_rw_d;
            cap_rom_sel_n_q <= cap_rom_sel_n_d;
            cap_sel_q       <= cap_sel_d;
            cap_d7_q        <= cap_d7_d;
            cap_d0_q        <= cap_d0_d;
        end
    end

    assign wr_event = (state_q == ST_EVAL) & ~cap_rw_q & ~cap_rom_sel_n_q;
    assign take     = wr_event & accept;

`ifdef MMC1_CONSEC_IGNORE_EN
    localparam int GW = $clog2(CONSEC_CLKS + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(CONSEC_CLKS);

    logic [GW-1:0] gap_q, gap_d;

    assign accept = (gap_q >= GAP_MAX);

    always_comb begin
        gap_d = gap_q;
        if (gap_q < GAP_MAX) gap_d = gap_q + 1'b1;
        if (take) gap_d = '0;
    end

    // Starts saturated so the first write after reset is never treated as a repeat.
    always_ff @(posedge clk) begin
        if (rst) gap_q <= GAP_MAX;
        else     gap_q <= gap_d;
    end
`else
    assign accept = 1'b1;
`endif

    assign commit_val = {cap_d0_q, shift_q[4:1]};

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        reg_wr_d  = 1'b0;

        case (state_q)
            ST_IDLE:    if (m2_rise) state_d = ST_M2_HIGH;
            ST_M2_HIGH: if (m2_fall) state_d = ST_EVAL;
            ST_EVAL:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Bit 7 resets the shifter ahead of any pending commit, even on the fifth write.
        if (take) begin
            if (cap_d7_q) begin
                shift_d   = 5'd0;
                count_d   = 3'd0;
                control_d = control_q | 5'h0C;
            end else if (count_q != 3'd4) begin
                shift_d = {cap_d0_q, shift_q[4:1]};
                count_d = count_q + 3'd1;
            end else begin
                case (cap_sel_q)
                    2'd0:    control_d = commit_val;
                    2'd1:    chr0_d    = commit_val;
                    2'd2:    chr1_d    = commit_val;
                    default: prg_d     = commit_val;
                endcase
                shift_d  = 5'd0;
                count_d  = 3'd0;
                reg_wr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= 5'd0;
            count_q   <= 3'd0;
            control_q <= 5'h0C;
            chr0_q    <= 5'd0;
            chr1_q    <= 5'd0;
            prg_q     <= 5'd0;
            reg_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
            reg_wr_q  <= reg_wr_d;
        end
    end

    always_comb begin
        case (control_q[3:2])
            2'd0, 2'd1: prg_addr_d = {prg_q[3:1], cpu.cpu_addr};
            2'd2: prg_addr_d = cpu.cpu_addr[14] ? {prg_q[3:0], cpu.cpu_addr[13:0]}
                                                : {4'h0, cpu.cpu_addr[13:0]};
            default: prg_addr_d = cpu.cpu_addr[14] ? {4'hF, cpu.cpu_addr[13:0]}
                                                   : {prg_q[3:0], cpu.cpu_addr[13:0]};
        endcase

        if (control_q[4]) chr_addr_d = {(ppu_addr[12] ? chr1_q : chr0_q), ppu_addr[11:0]};
        else              chr_addr_d = {chr0_q[4:1], ppu_addr};

        case (control_q[1:0])
            2'd0:    ciram_a10_d = 1'b0;
            2'd1:    ciram_a10_d = 1'b1;
            2'd2:    ciram_a10_d = ppu_addr[10];
            default: ciram_a10_d = ppu_addr[11];
        endcase
    end

    // Address outputs need no reset: they reload every clk from the (reset) registers.
    always_ff @(posedge clk) begin
        prg_addr_q <= prg_addr_d;
        chr_addr_q <= chr_addr_d;
        if (rst) ciram_a10_q <= 1'b0;
        else     ciram_a10_q <= ciram_a10_d;
    end

    assign prg_addr  = prg_addr_q;
    assign chr_addr  = chr_addr_q;
    assign ciram_a10 = ciram_a10_q;
    assign wram_en_n = prg_q[4];
    assign reg_wr    = reg_wr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mmc1_write_decoder.sv
// Bench for mmc1_write_decoder: directed protocol scenarios plus random CPU bus cycles,
// checked against a register-level model of the MMC1 serial load and address mapping.
module tb_mmc1_write_decoder;
    localparam int CONSEC_CLKS = 40;
`ifdef MMC1_CONSEC_IGNORE_EN
    localparam bit CONSEC_EN = 1'b1;
`else
    localparam bit CONSEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] ppu_addr;
    logic [17:0] prg_addr;
    logic [16:0] chr_addr;
    logic        ciram_a10;
    logic        wram_en_n;
    logic        reg_wr;
    logic [1:0]  dbg_state;

    mmc1_write_decoder_if cpu_bus ();

    mmc1_write_decoder #(
        .SYNC_STAGES (2),
        .CONSEC_CLKS (CONSEC_CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu_bus),
        .ppu_addr  (ppu_addr),
        .prg_addr  (prg_addr),
        .chr_addr  (chr_addr),
        .ciram_a10 (ciram_a10),
        .wram_en_n (wram_en_n),
        .reg_wr    (reg_wr),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    int cyc     = 0;
    int wr_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (reg_wr === 1'b1) wr_seen <= wr_seen + 1;

    // ---------------- scoreboard / model ----------------
    int n_vec = 0;
    int n_err = 0;

    int m_ctrl, m_chr0, m_chr1, m_prg;
    int exp_wr = 0;
    logic [0:0] exp_q[$];   // pending serial bits, oldest first
    bit  have_last;
    int  last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 12;
        m_chr0 = 0;
        m_chr1 = 0;
        m_prg  = 0;
        exp_q.delete();
        have_last = 1'b0;
        last_acc  = 0;
    endtask

    task automatic model_write(input logic rw, input logic rs_n, input logic [14:0] a,
                               input logic [7:0] d, input int t);
        int v;
        bit too_soon;
        if (rw || rs_n) return;
        too_soon = have_last && ((t - last_acc) < CONSEC_CLKS);
        if (CONSEC_EN && too_soon) return;
        have_last = 1'b1;
        last_acc  = t;
        if (d[7]) begin
            exp_q.delete();
            m_ctrl = m_ctrl | 12;
            return;
        end
        exp_q.push_back(d[0]);
        if (exp_q.size() == 5) begin
            v = 0;
            foreach (exp_q[i]) if (exp_q[i] == 1'b1) v += (1 << i);
            case (int'(a) / 8192)
                0:       m_ctrl = v;
                1:       m_chr0 = v;
                2:       m_chr1 = v;
                default: m_prg  = v;
            endcase
            exp_q.delete();
            exp_wr++;
        end
    endtask

    function automatic int exp_prg(input int a);
        int bank = m_prg % 16;
        int lo   = a % 16384;
        case ((m_ctrl / 4) % 4)
            0, 1:    return (bank / 2) * 32768 + a;
            2:       return (a >= 16384) ? bank * 16384 + lo : lo;
            default: return (a >= 16384) ? 15 * 16384 + lo : bank * 16384 + lo;
        endcase
    endfunction

    function automatic int exp_chr(input int p);
        if (((m_ctrl / 16) % 2) == 0) return (m_chr0 / 2) * 8192 + p;
        return ((p >= 4096) ? m_chr1 : m_chr0) * 4096 + (p % 4096);
    endfunction

    function automatic int exp_ciram(input int p);
        case (m_ctrl % 4)
            0:       return 0;
            1:       return 1;
            2:       return (p / 1024) % 2;
            default: return (p / 2048) % 2;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_cycle(input logic rw, input logic rs_n, input logic [14:0] a,
                             input logic [7:0] d, input int hi, input int lo);
        int seen0, exp0;
        @(negedge clk);
        cpu_bus.cpu_rw        = rw;
        cpu_bus.cpu_rom_sel_n = rs_n;
        cpu_bus.cpu_addr      = a;
        cpu_bus.cpu_data_in   = d;
        cpu_bus.cpu_m2        = 1'b1;
        repeat (hi) @(negedge clk);
        seen0 = wr_seen;
        exp0  = exp_wr;
        cpu_bus.cpu_m2 = 1'b0;
        model_write(rw, rs_n, a, d, cyc);
        repeat (lo) @(negedge clk);
        check("reg_wr_pulses", 32'(wr_seen - seen0), 32'(exp_wr - exp0));
    endtask

    task automatic write_reg(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) bus_cycle(1'b0, 1'b0, a, {7'd0, v[i]}, 6, 50);
    endtask

    task automatic check_map(input logic [14:0] a, input logic [12:0] p);
        @(negedge clk);
        cpu_bus.cpu_addr = a;
        ppu_addr         = p;
        repeat (2) @(negedge clk);
        check("prg_addr",  32'(prg_addr),  32'(exp_prg(int'(a))));
        check("chr_addr",  32'(chr_addr),  32'(exp_chr(int'(p))));
        check("ciram_a10", 32'(ciram_a10), 32'(exp_ciram(int'(p))));
        check("wram_en_n", 32'(wram_en_n), 32'((m_prg / 16) % 2));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0]  pat;
        logic [7:0]  rd;
        logic [14:0] ra;
        int          seen0;

        cpu_bus.cpu_m2        = 1'b0;
        cpu_bus.cpu_rw        = 1'b1;
        cpu_bus.cpu_rom_sel_n = 1'b1;
        cpu_bus.cpu_addr      = 15'd0;
        cpu_bus.cpu_data_in   = 8'd0;
        ppu_addr              = 13'd0;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_reg_wr",    32'(reg_wr),    32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        check("rst_wram_en_n", 32'(wram_en_n), 32'd0);
        check("rst_ciram_a10", 32'(ciram_a10), 32'd0);

        // Reads and non-ROM writes must leave everything untouched.
        for (int i = 0; i < 5; i++) bus_cycle(1'b1, 1'b0, 15'h6000, 8'h01, 6, 50);
        bus_cycle(1'b0, 1'b1, 15'h6000, 8'h01, 6, 50);
        check_map(15'h4000, 13'h0000);
        check("prg_mode3_fixed", 32'(prg_addr), 32'h3C000);

        pat = 5'b01010;
        write_reg(15'h6000, pat);
        check_map(15'h0123, 13'h0456);
        check("prg_bank_0a", 32'(prg_addr), 32'h28123);

        // Reset bit mid-sequence discards the three partial bits.
        for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b0, 15'h0000, 8'h01, 6, 50);
        bus_cycle(1'b0, 1'b0, 15'h0000, 8'h80, 6, 50);
        write_reg(15'h0000, 5'h00);
        check_map(15'h5555, 13'h0C00);
        check("ciram_mirror0", 32'(ciram_a10), 32'd0);

        write_reg(15'h2000, 5'h03);
        write_reg(15'h4000, 5'h1F);
        write_reg(15'h0000, 5'h10);
        check_map(15'h1234, 13'h1ABC);
        check("chr_hi_bank", 32'(chr_addr), 32'h1FABC);
        check_map(15'h1234, 13'h0ABC);
        check("chr_lo_bank", 32'(chr_addr), 32'h03ABC);

        write_reg(15'h0000, 5'h02);
        check_map(15'h0000, 13'h0400);
        check_map(15'h0000, 13'h0800);
        write_reg(15'h0000, 5'h03);
        check_map(15'h0000, 13'h0800);
        check_map(15'h0000, 13'h0400);

        // Closely spaced write pair (30 clks fall to fall), then a widely spaced pair (60).
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h80, 6, 50);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h01, 10, 19);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h01, 10, 50);
        for (int i = 0; i < 4; i++) bus_cycle(1'b0, 1'b0, 15'h6000, 8'h00, 6, 50);
        check_map(15'h2345, 13'h0123);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h80, 6, 50);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h01, 10, 49);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h01, 10, 50);
        for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b0, 15'h6000, 8'h00, 6, 50);
        check_map(15'h2345, 13'h0123);

        for (int n = 0; n < 150; n++) begin
            rd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rd[7] = 1'b1;
            else                           rd[7] = 1'b0;
            ra = 15'($urandom_range(0, 32767));
            bus_cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), ra, rd,
                      $urandom_range(3, 12), $urandom_range(45, 60));
            if (n % 5 == 4) check_map(15'($urandom_range(0, 32767)), 13'($urandom_range(0, 8191)));
        end

        // Reset in the middle of a serial load.
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h80, 6, 50);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h01, 6, 50);
        bus_cycle(1'b0, 1'b0, 15'h6000, 8'h01, 6, 50);
        reset_dut();
        check_map(15'h4000, 13'h0000);
        write_reg(15'h6000, 5'h13);
        check_map(15'h0ABC, 13'h1111);

        // M2 already high when reset releases: that cycle must be ignored.
        @(negedge clk);
        cpu_bus.cpu_rw        = 1'b0;
        cpu_bus.cpu_rom_sel_n = 1'b0;
        cpu_bus.cpu_addr      = 15'h6000;
        cpu_bus.cpu_data_in   = 8'h01;
        cpu_bus.cpu_m2        = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen0 = wr_seen;
        repeat (5) @(negedge clk);
        cpu_bus.cpu_m2 = 1'b0;
        repeat (20) @(negedge clk);
        check("m2_high_at_release", 32'(wr_seen - seen0), 32'd0);
        write_reg(15'h6000, 5'h0E);
        check_map(15'h0321, 13'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
